slice_ctrl: RTL and testbench

SLICE_CTRL -- requirements
Module: slice_ctrl

---
 rtl/slice_pkg.sv | 8 +
 rtl/slice_hist.sv | 48 ++++
 rtl/slice_ctrl.sv | 137 +++++++++++++
 tb/tb_slice_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_pkg.sv
// slice_pkg: shared types and constants for the katana slice controller
package slice_pkg;
  typedef enum logic [2:0] {FILL, TRACK, REQ, WAIT, HOLD} state_t;
  localparam int HIST_DEPTH = 8;
  localparam logic [10:0] FRAME_END_H = 11'd1024;
  localparam logic [9:0] FRAME_END_V = 10'd768;
  typedef logic signed [15:0] angle_t;
endpackage

// File: rtl/slice_hist.sv
// slice_hist: per-frame katana position history with window displacement and speed
module slice_hist
  import slice_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               shift,
  input  logic [10:0]        x_in,
  input  logic [9:0]         y_in,
  output logic signed [11:0] dx,
  output logic signed [10:0] dy,
  output logic [12:0]        speed
);
  logic [10:0] x_q [HIST_DEPTH];
  logic [10:0] x_d [HIST_DEPTH];
  logic [9:0]  y_q [HIST_DEPTH];
  logic [9:0]  y_d [HIST_DEPTH];
  logic [11:0] adx;
  logic [10:0] ady;
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (shift) begin
      x_d[0] = x_in;
      y_d[0] = y_in;
      for (int i = 1; i < HIST_DEPTH; i++) begin
        x_d[i] = x_q[i-1];
        y_d[i] = y_q[i-1];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '{default: '0};
      y_q <= '{default: '0};
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
  always_comb begin
    dx    = {1'b0, x_q[0]} - {1'b0, x_q[HIST_DEPTH-1]};
    dy    = {1'b0, y_q[0]} - {1'b0, y_q[HIST_DEPTH-1]};
    adx   = dx[11] ? -dx : dx;
    ady   = dy[10] ? -dy : dy;
    speed = {1'b0, adx} + {2'b00, ady};
  end
endmodule

// File: rtl/slice_ctrl.sv
// slice_ctrl: detects katana slices from motion history and latches one swing angle per slice
module slice_ctrl
  import slice_pkg::*;
#(
  parameter int SPEED_THRESH    = 64,
  parameter int COOLDOWN_FRAMES = 4,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic               pixel_clk_in,
  input  logic               rst_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic [10:0]        katana_x,
  input  logic [9:0]         katana_y,
  output logic               atan_start,
  output logic signed [11:0] atan_dx,
  output logic signed [10:0] atan_dy,
  input  logic               atan_done,
  input  logic [15:0]        atan_angle,
  output logic               slice_active,
  output logic               slice_valid,
  output logic [15:0]        slice_angle,
  output logic               slice_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  logic               frame_done;
  logic signed [11:0] dx;
  logic signed [10:0] dy;
  logic [12:0]        speed;
  state_t             state_q, state_d;
  logic [2:0]         fill_q, fill_d;
  logic               fd_q, fd_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [CW-1:0]      cool_q, cool_d;
  logic signed [11:0] dx_q, dx_d;
  logic signed [10:0] dy_q, dy_d;
  logic               active_q, active_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  angle_t             angle_q, angle_d;
  assign frame_done = (hcount_in == FRAME_END_H) && (vcount_in == FRAME_END_V);
  slice_hist u_hist (
    .clk   (pixel_clk_in),
    .rst   (rst_in),
    .shift (frame_done),
    .x_in  (katana_x),
    .y_in  (katana_y),
    .dx    (dx),
    .dy    (dy),
    .speed (speed)
  );
  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    fd_d     = frame_done;
    tmo_d    = tmo_q;
    cool_d   = cool_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    active_d = active_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    angle_d  = angle_q;
    case (state_q)
      FILL: if (frame_done) begin
        fill_d  = fill_q + 3'd1;
        state_d = (fill_q == 3'(HIST_DEPTH - 1)) ? TRACK : FILL;
      end
      TRACK: if (fd_q && speed >= 13'(SPEED_THRESH)) begin
        dx_d     = dx;
        dy_d     = dy;
        active_d = 1'b1;
        state_d  = REQ;
      end
      REQ: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: if (atan_done) begin
        angle_d = atan_angle;
        valid_d = 1'b1;
        cool_d  = '0;
        state_d = HOLD;
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 2)) begin
        err_d    = 1'b1;
        active_d = 1'b0;
        state_d  = TRACK;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
      HOLD: if (fd_q) begin
        cool_d = (speed >= 13'(SPEED_THRESH)) ? '0 : cool_q + 1'b1;
        if (speed < 13'(SPEED_THRESH) && cool_q == CW'(COOLDOWN_FRAMES - 1)) begin
          cool_d   = '0;
          active_d = 1'b0;
          state_d  = TRACK;
        end
      end
      default: state_d = FILL;
    endcase
  end
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q  <= FILL;
      fill_q   <= '0;
      fd_q     <= 1'b0;
      tmo_q    <= '0;
      cool_q   <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      angle_q  <= '0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      fd_q     <= fd_d;
      tmo_q    <= tmo_d;
      cool_q   <= cool_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      active_q <= active_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      angle_q  <= angle_d;
    end
  end
  assign atan_start   = (state_q == REQ);
  assign atan_dx      = dx_q;
  assign atan_dy      = dy_q;
  assign slice_active = active_q;
  assign slice_valid  = valid_q;
  assign slice_angle  = angle_q;
  assign slice_err    = err_q;
endmodule

// File: tb/tb_slice_ctrl.sv
// tb_slice_ctrl: directed scenario bench for slice_ctrl
module tb_slice_ctrl;
  import slice_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] h = '0;
  logic [9:0]  v = '0;
  logic [10:0] kx = '0;
  logic [9:0]  ky = '0;
  logic        done = 1'b0;
  logic [15:0] ang = '0;
  logic        start, act, vld, err;
  logic [11:0] adx;
  logic [10:0] ady;
  logic [15:0] sang;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  slice_ctrl dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .hcount_in    (h),
    .vcount_in    (v),
    .katana_x     (kx),
    .katana_y     (ky),
    .atan_start   (start),
    .atan_dx      (adx),
    .atan_dy      (ady),
    .atan_done    (done),
    .atan_angle   (ang),
    .slice_active (act),
    .slice_valid  (vld),
    .slice_angle  (sang),
    .slice_err    (err)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic frame(input logic [10:0] x, input logic [9:0] y);
    step();
    kx = x;
    ky = y;
    h = 11'd1024;
    v = 10'd768;
    step();
    h = '0;
    v = '0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    done = 1'b0;
    h = '0;
    v = '0;
    step();
    step();
    rst = 1'b0;
  endtask
  task automatic fill_diag();
    for (int i = 0; i < 8; i++) frame(11'(300 + 8 * i), 10'(400 - 8 * i));
  endtask
  task automatic test_reset();
    rst = 1'b1;
    done = 1'b1;
    step();
    step();
    checks++;
    if ({start, act, vld, err} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {start, act, vld, err}); end
    checks++;
    if ({adx, ady, sang} !== 39'b0) begin errors++; $display("FAIL reset_data: got dx=%h dy=%h ang=%h want 0", adx, ady, sang); end
    checks++;
    if (dut.state_q !== FILL) begin errors++; $display("FAIL reset_state: got %0d want FILL", dut.state_q); end
    done = 1'b0;
    rst = 1'b0;
  endtask
  task automatic test_fill_static();
    logic seen = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) frame(11'd100, 10'd100);
    checks++;
    if (dut.state_q !== FILL) begin errors++; $display("FAIL fill_7: got %0d want FILL", dut.state_q); end
    frame(11'd100, 10'd100);
    checks++;
    if (dut.state_q !== TRACK) begin errors++; $display("FAIL fill_8: got %0d want TRACK", dut.state_q); end
    for (int i = 0; i < 5; i++) begin step(); seen |= start; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL fill_nostart: got %b want 0", seen); end
  endtask
  task automatic test_x_motion();
    logic seen = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) frame(11'd200, 10'd300);
    for (int i = 1; i < 7; i++) begin
      frame(11'(200 + 10 * i), 10'd300);
      step();
      seen |= start;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL x_early: got %b want 0", seen); end
    frame(11'd270, 10'd300);
    checks++;
    if (start !== 1'b0) begin errors++; $display("FAIL x_lat1: got %b want 0", start); end
    step();
    checks++;
    if ({start, act, adx, ady} !== {1'b1, 1'b1, 12'd70, 11'd0}) begin
      errors++; $display("FAIL x_start: got start=%b act=%b dx=%0d dy=%0d want 1 1 70 0", start, act, adx, ady);
    end
    step();
    checks++;
    if (start !== 1'b0) begin errors++; $display("FAIL x_onecycle: got %b want 0", start); end
    done = 1'b1;
    ang = 16'h0000;
    step();
    done = 1'b0;
    checks++;
    if ({vld, sang} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL x_valid: got vld=%b ang=%h want 1 0000", vld, sang); end
    step();
    checks++;
    if (vld !== 1'b0 || dut.state_q !== HOLD) begin errors++; $display("FAIL x_pulse: got vld=%b st=%0d want 0 HOLD", vld, dut.state_q); end
    done = 1'b1;
    ang = 16'h5555;
    step();
    done = 1'b0;
    step();
    checks++;
    if ({vld, sang} !== {1'b0, 16'h0000}) begin errors++; $display("FAIL x_stray_done: got vld=%b ang=%h want 0 0000", vld, sang); end
  endtask
  task automatic test_diag();
    logic seen = 1'b0;
    logic held = 1'b1;
    do_reset();
    fill_diag();
    step();
    checks++;
    if ({start, adx, ady} !== {1'b1, 12'd56, 11'h7C8}) begin
      errors++; $display("FAIL d_start: got start=%b dx=%h dy=%h want 1 038 7c8", start, adx, ady);
    end
    step();
    done = 1'b1;
    ang = 16'hF36F;
    step();
    done = 1'b0;
    checks++;
    if ({vld, sang} !== {1'b1, 16'hF36F}) begin errors++; $display("FAIL d_valid: got vld=%b ang=%h want 1 f36f", vld, sang); end
    for (int k = 1; k < 7; k++) begin
      frame(11'd356, 10'd344);
      step();
      seen |= start;
      held &= act;
    end
    checks++;
    if ({seen, held} !== 2'b01) begin errors++; $display("FAIL d_hold: got start_seen=%b active_held=%b want 0 1", seen, held); end
    frame(11'd356, 10'd344);
    step();
    checks++;
    if ({act, sang} !== {1'b0, 16'hF36F} || dut.state_q !== TRACK) begin
      errors++; $display("FAIL d_exit: got act=%b ang=%h st=%0d want 0 f36f TRACK", act, sang, dut.state_q);
    end
  endtask
  task automatic test_timeout();
    do_reset();
    fill_diag();
    step();
    step();
    done = 1'b1;
    ang = 16'h1234;
    step();
    done = 1'b0;
    for (int k = 0; k < 7; k++) frame(11'd356, 10'd344);
    for (int j = 1; j < 8; j++) frame(11'(356 + 10 * j), 10'd344);
    step();
    checks++;
    if ({start, adx} !== {1'b1, 12'd70}) begin errors++; $display("FAIL t_start: got start=%b dx=%0d want 1 70", start, adx); end
    for (int i = 1; i <= 256; i++) begin
      step();
      kx = 11'd500;
      h = (i == 3) ? 11'd1024 : 11'd0;
      v = (i == 3) ? 10'd768 : 10'd0;
      if (i == 10) begin
        checks++;
        if (adx !== 12'd70) begin errors++; $display("FAIL t_frozen: got dx=%0d want 70", adx); end
      end
      if (i == 255) begin
        checks++;
        if ({err, act} !== 2'b01) begin errors++; $display("FAIL t_early: got err=%b act=%b want 0 1", err, act); end
      end
    end
    checks++;
    if ({err, act, sang} !== {1'b1, 1'b0, 16'h1234} || dut.state_q !== TRACK) begin
      errors++; $display("FAIL t_err: got err=%b act=%b ang=%h st=%0d want 1 0 1234 TRACK", err, act, sang, dut.state_q);
    end
    step();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL t_pulse: got %b want 0", err); end
  endtask
  task automatic test_reset_wait();
    logic seen = 1'b0;
    do_reset();
    fill_diag();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    done = 1'b1;
    ang = 16'h7777;
    step();
    done = 1'b0;
    seen = vld;
    step();
    seen |= vld;
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rw_valid: got %b want 0", seen); end
    checks++;
    if ({start, act, err, adx, ady, sang} !== 42'b0) begin
      errors++; $display("FAIL rw_outs: got start=%b act=%b err=%b dx=%h dy=%h ang=%h want 0", start, act, err, adx, ady, sang);
    end
    checks++;
    if (dut.state_q !== FILL) begin errors++; $display("FAIL rw_state: got %0d want FILL", dut.state_q); end
  endtask
  task automatic test_threshold();
    do_reset();
    for (int i = 0; i < 8; i++) frame(11'd100, 10'd100);
    frame(11'd140, 10'd77);
    step();
    checks++;
    if (start !== 1'b0 || dut.state_q !== TRACK) begin errors++; $display("FAIL th_63: got start=%b st=%0d want 0 TRACK", start, dut.state_q); end
    frame(11'd140, 10'd76);
    step();
    checks++;
    if ({start, adx, ady} !== {1'b1, 12'd40, 11'h7E8}) begin
      errors++; $display("FAIL th_64: got start=%b dx=%h dy=%h want 1 028 7e8", start, adx, ady);
    end
  endtask
  initial begin
    test_reset();
    test_fill_static();
    test_x_motion();
    test_diag();
    test_timeout();
    test_reset_wait();
    test_threshold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
